// File: rtl/dp_seq_pkg.sv
// Shared types and ISA constants for the data-processing instruction sequencer.
package dp_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } seq_state_e;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_EOR = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_RSB = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_ADC = 4'd5;
    localparam logic [3:0] OP_SBC = 4'd6;
    localparam logic [3:0] OP_RSC = 4'd7;
    localparam logic [3:0] OP_TST = 4'd8;
    localparam logic [3:0] OP_TEQ = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;
    localparam logic [3:0] OP_CMN = 4'd11;
    localparam logic [3:0] OP_ORR = 4'd12;
    localparam logic [3:0] OP_MOV = 4'd13;
    localparam logic [3:0] OP_BIC = 4'd14;
    localparam logic [3:0] OP_MVN = 4'd15;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [3:0] CC_EQ = 4'd0;
    localparam logic [3:0] CC_NE = 4'd1;
    localparam logic [3:0] CC_CS = 4'd2;
    localparam logic [3:0] CC_CC = 4'd3;
    localparam logic [3:0] CC_MI = 4'd4;
    localparam logic [3:0] CC_PL = 4'd5;
    localparam logic [3:0] CC_VS = 4'd6;
    localparam logic [3:0] CC_VC = 4'd7;
    localparam logic [3:0] CC_HI = 4'd8;
    localparam logic [3:0] CC_LS = 4'd9;
    localparam logic [3:0] CC_GE = 4'd10;
    localparam logic [3:0] CC_LT = 4'd11;
    localparam logic [3:0] CC_GT = 4'd12;
    localparam logic [3:0] CC_LE = 4'd13;
    localparam logic [3:0] CC_AL = 4'd14;
    localparam logic [3:0] CC_NV = 4'd15;

    // Compare/test opcodes (TST..CMN) only produce flags, never a register write.
    function automatic logic is_test_op(input logic [3:0] op);
        return (op >= OP_TST) && (op <= OP_CMN);
    endfunction

endpackage

// File: rtl/dp_instr_sequencer_cond_check.sv
// Combinational ARM condition-code evaluator; nzcv is {N,Z,C,V}.
module cond_check
    import dp_seq_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);

    logic n, z, c, v;

    assign n = nzcv_i[3];
    assign z = nzcv_i[2];
    assign c = nzcv_i[1];
    assign v = nzcv_i[0];

    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            CC_EQ: pass_o = z;
            CC_NE: pass_o = !z;
            CC_CS: pass_o = c;
            CC_CC: pass_o = !c;
            CC_MI: pass_o = n;
            CC_PL: pass_o = !n;
            CC_VS: pass_o = v;
            CC_VC: pass_o = !v;
            CC_HI: pass_o = c && !z;
            CC_LS: pass_o = !c || z;
            CC_GE: pass_o = (n == v);
            CC_LT: pass_o = (n != v);
            CC_GT: pass_o = !z && (n == v);
            CC_LE: pass_o = z || (n != v);
            CC_AL: pass_o = 1'b1;
            CC_NV: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_instr_sequencer.sv
// Four-phase issue controller for ARM data-processing instructions; owns NZCV.
// Define DP_SEQ_ILLEGAL_TRAP_EN to trap illegal encodings with a sticky flag.
module dp_instr_sequencer
    import dp_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    output logic [3:0]  rf_raddr_c,
    input  logic [31:0] rf_rdata_a,
    input  logic [31:0] rf_rdata_b,
    input  logic [31:0] rf_rdata_c,
    output logic [31:0] alu_a,
    output logic [31:0] shift_data,
    output logic [7:0]  shift_num,
    output logic [2:0]  shift_op,
    output logic [3:0]  alu_op,
    output logic        write_nzcv,
    input  logic [31:0] alu_f,
    input  logic [3:0]  alu_nzcv,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [3:0]  nzcv,
    output logic        done,
    output logic        skipped,
    output logic        illegal
);

    seq_state_e  state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] rn_q, rn_d;
    logic [31:0] rm_q, rm_d;
    logic [31:0] rs_q, rs_d;
    logic [31:0] f_q, f_d;
    logic [3:0]  fl_q, fl_d;
    logic [3:0]  nzcv_q, nzcv_d;
    logic        cond_pass;
    logic        enc_illegal;
    logic        accept_en;

    cond_check u_cond_check (
        .cond_i (ir_q[31:28]),
        .nzcv_i (nzcv_q),
        .pass_o (cond_pass)
    );

    assign enc_illegal = (ir_q[27:26] != 2'b00) || (is_test_op(ir_q[24:21]) && !ir_q[20]);
    assign nzcv        = nzcv_q;

`ifdef DP_SEQ_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    assign accept_en = !illegal_q;
    assign illegal   = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end
`else
    assign accept_en = 1'b1;
    assign illegal   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        rn_d        = rn_q;
        rm_d        = rm_q;
        rs_d        = rs_q;
        f_d         = f_q;
        fl_d        = fl_q;
        nzcv_d      = nzcv_q;
`ifdef DP_SEQ_ILLEGAL_TRAP_EN
        illegal_d   = illegal_q;
`endif
        instr_ready = 1'b0;
        rf_raddr_a  = 4'd0;
        rf_raddr_b  = 4'd0;
        rf_raddr_c  = 4'd0;
        alu_a       = 32'd0;
        shift_data  = 32'd0;
        shift_num   = 8'd0;
        shift_op    = 3'd0;
        alu_op      = 4'd0;
        write_nzcv  = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = 4'd0;
        rf_wdata    = 32'd0;
        done        = 1'b0;
        skipped     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                instr_ready = accept_en;
                if (instr_valid && accept_en) begin
                    ir_d    = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                rf_raddr_a = ir_q[19:16];
                rf_raddr_b = ir_q[3:0];
                rf_raddr_c = ir_q[11:8];
                rn_d       = rf_rdata_a;
                rm_d       = rf_rdata_b;
                rs_d       = rf_rdata_c;
                if (enc_illegal) begin
`ifdef DP_SEQ_ILLEGAL_TRAP_EN
                    illegal_d = 1'b1;
`else
                    skipped   = 1'b1;
`endif
                    state_d = ST_IDLE;
                end else if (!cond_pass) begin
                    skipped = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_a      = rn_q;
                alu_op     = ir_q[24:21];
                write_nzcv = ir_q[20];
                if (ir_q[25]) begin
                    // Rotated immediate: 8-bit value, ROR by twice the 4-bit field.
                    shift_data = {24'd0, ir_q[7:0]};
                    shift_num  = {3'b000, ir_q[11:8], 1'b0};
                    shift_op   = {SH_ROR, 1'b0};
                end else if (!ir_q[4]) begin
                    shift_data = rm_q;
                    shift_num  = {3'b000, ir_q[11:7]};
                    shift_op   = {ir_q[6:5], 1'b0};
                end else begin
                    shift_data = rm_q;
                    shift_num  = rs_q[7:0];
                    shift_op   = {ir_q[6:5], 1'b1};
                end
                f_d     = alu_f;
                fl_d    = alu_nzcv;
                state_d = ST_WB;
            end
            ST_WB: begin
                rf_we    = !is_test_op(ir_q[24:21]);
                rf_waddr = ir_q[15:12];
                rf_wdata = f_q;
                if (ir_q[20]) nzcv_d = fl_q;
                done     = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ir_q    <= 32'd0;
            rn_q    <= 32'd0;
            rm_q    <= 32'd0;
            rs_q    <= 32'd0;
            f_q     <= 32'd0;
            fl_q    <= 4'd0;
            nzcv_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            rs_q    <= rs_d;
            f_q     <= f_d;
            fl_q    <= fl_d;
            nzcv_q  <= nzcv_d;
        end
    end

endmodule

// File: tb/tb_dp_instr_sequencer.sv
// Directed-vector bench for dp_instr_sequencer; the bench plays register file and ALU.
module tb_dp_instr_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [3:0]  rf_raddr_a, rf_raddr_b, rf_raddr_c;
    logic [31:0] rf_rdata_a, rf_rdata_b, rf_rdata_c;
    logic [31:0] alu_a, shift_data;
    logic [7:0]  shift_num;
    logic [2:0]  shift_op;
    logic [3:0]  alu_op;
    logic        write_nzcv;
    logic [31:0] alu_f;
    logic [3:0]  alu_nzcv;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  nzcv;
    logic        done, skipped, illegal;

    logic [31:0] rf [16];
    int n_vec = 0;
    int n_err = 0;

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];
    assign rf_rdata_c = rf[rf_raddr_c];

    dp_instr_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .rf_raddr_c  (rf_raddr_c),
        .rf_rdata_a  (rf_rdata_a),
        .rf_rdata_b  (rf_rdata_b),
        .rf_rdata_c  (rf_rdata_c),
        .alu_a       (alu_a),
        .shift_data  (shift_data),
        .shift_num   (shift_num),
        .shift_op    (shift_op),
        .alu_op      (alu_op),
        .write_nzcv  (write_nzcv),
        .alu_f       (alu_f),
        .alu_nzcv    (alu_nzcv),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .nzcv        (nzcv),
        .done        (done),
        .skipped     (skipped),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake at the next edge; returns in cycle 1 (DECODE).
    task automatic send(input logic [31:0] ins);
        instr       = ins;
        instr_valid = 1'b1;
        check_vec("ready_before_send", 32'(instr_ready), 1);
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0;
        alu_f = 32'd0; alu_nzcv = 4'd0;
        for (int i = 0; i < 16; i++) rf[i] = 32'd0;
        rf[2] = 32'hFFFF_FFFF; rf[3] = 32'd7; rf[4] = 32'd7;
        rf[6] = 32'd1; rf[7] = 32'd4; rf[10] = 32'd100; rf[11] = 32'h8000_0000;

        repeat (2) step();
        check_vec("rst_ready", 32'(instr_ready), 1);
        check_vec("rst_nzcv", 32'(nzcv), 0);
        check_vec("rst_done", 32'(done), 0);
        check_vec("rst_we", 32'(rf_we), 0);
        check_vec("rst_illegal", 32'(illegal), 0);
        check_vec("rst_aluop", 32'(alu_op), 0);
        rst_n = 1'b1;
        step();

        // ADDS R1,R2,#1 with R2=-1
        alu_f = 32'd0; alu_nzcv = 4'b0110;
        send(32'hE292_1001);
        check_vec("adds_raddr_a", 32'(rf_raddr_a), 2);
        check_vec("adds_ready_c1", 32'(instr_ready), 0);
        check_vec("adds_skip_c1", 32'(skipped), 0);
        step();
        check_vec("adds_alu_a", alu_a, 32'hFFFF_FFFF);
        check_vec("adds_sdata", shift_data, 1);
        check_vec("adds_snum", 32'(shift_num), 0);
        check_vec("adds_sop", 32'(shift_op), 6);
        check_vec("adds_aluop", 32'(alu_op), 4);
        check_vec("adds_wnzcv", 32'(write_nzcv), 1);
        check_vec("adds_we_c2", 32'(rf_we), 0);
        step();
        check_vec("adds_we_c3", 32'(rf_we), 1);
        check_vec("adds_waddr", 32'(rf_waddr), 1);
        check_vec("adds_wdata", rf_wdata, 0);
        check_vec("adds_done_c3", 32'(done), 1);
        check_vec("adds_aluop_c3", 32'(alu_op), 0);
        check_vec("adds_nzcv_c3", 32'(nzcv), 0);
        step();
        check_vec("adds_nzcv_c4", 32'(nzcv), 6);
        check_vec("adds_ready_c4", 32'(instr_ready), 1);
        check_vec("adds_done_c4", 32'(done), 0);

        // MOVNE R0,#5 with Z=1: annulled, then CMP accepted in cycle 2
        send(32'h13A0_0005);
        check_vec("movne_skip_c1", 32'(skipped), 1);
        check_vec("movne_we_c1", 32'(rf_we), 0);
        step();
        check_vec("movne_skip_c2", 32'(skipped), 0);
        check_vec("movne_done_c2", 32'(done), 0);

        // CMP R3,R4 with R3=R4=7
        alu_f = 32'd0; alu_nzcv = 4'b0110;
        send(32'hE153_0004);
        check_vec("cmp_raddr_a", 32'(rf_raddr_a), 3);
        check_vec("cmp_raddr_b", 32'(rf_raddr_b), 4);
        step();
        check_vec("cmp_alu_a", alu_a, 7);
        check_vec("cmp_sdata", shift_data, 7);
        check_vec("cmp_aluop", 32'(alu_op), 10);
        check_vec("cmp_sop", 32'(shift_op), 0);
        step();
        check_vec("cmp_we_c3", 32'(rf_we), 0);
        check_vec("cmp_done_c3", 32'(done), 1);
        step();
        check_vec("cmp_nzcv_c4", 32'(nzcv), 6);

        // MOVEQ R8,#0xFF ROR 8 with Z=1: executes
        alu_f = 32'hFF00_0000; alu_nzcv = 4'b1000;
        send(32'h03A0_84FF);
        check_vec("moveq_skip_c1", 32'(skipped), 0);
        step();
        check_vec("moveq_sdata", shift_data, 32'hFF);
        check_vec("moveq_snum", 32'(shift_num), 8);
        check_vec("moveq_sop", 32'(shift_op), 6);
        check_vec("moveq_wnzcv", 32'(write_nzcv), 0);
        step();
        check_vec("moveq_we", 32'(rf_we), 1);
        check_vec("moveq_waddr", 32'(rf_waddr), 8);
        check_vec("moveq_wdata", rf_wdata, 32'hFF00_0000);
        step();
        check_vec("moveq_nzcv_kept", 32'(nzcv), 6);

        // MOV R5,R6,LSL R7 with R6=1, R7=4
        alu_f = 32'h10; alu_nzcv = 4'b1001;
        send(32'hE1A0_5716);
        check_vec("movr_raddr_b", 32'(rf_raddr_b), 6);
        check_vec("movr_raddr_c", 32'(rf_raddr_c), 7);
        step();
        check_vec("movr_sdata", shift_data, 1);
        check_vec("movr_snum", 32'(shift_num), 4);
        check_vec("movr_sop", 32'(shift_op), 1);
        check_vec("movr_aluop", 32'(alu_op), 13);
        step();
        check_vec("movr_we", 32'(rf_we), 1);
        check_vec("movr_waddr", 32'(rf_waddr), 5);
        check_vec("movr_wdata", rf_wdata, 32'h10);
        step();
        check_vec("movr_nzcv_kept", 32'(nzcv), 6);

        // SUBS R9,R10,R11,ASR #3: clears flags
        alu_f = 32'h1000_0064; alu_nzcv = 4'b0000;
        send(32'hE05A_91CB);
        step();
        check_vec("subs_alu_a", alu_a, 100);
        check_vec("subs_sdata", shift_data, 32'h8000_0000);
        check_vec("subs_snum", 32'(shift_num), 3);
        check_vec("subs_sop", 32'(shift_op), 4);
        check_vec("subs_aluop", 32'(alu_op), 2);
        step();
        check_vec("subs_waddr", 32'(rf_waddr), 9);
        check_vec("subs_wdata", rf_wdata, 32'h1000_0064);
        step();
        check_vec("subs_nzcv", 32'(nzcv), 0);

        // MOVNE R0,#5 with Z=0 now executes
        alu_f = 32'd5; alu_nzcv = 4'b0000;
        send(32'h13A0_0005);
        check_vec("movne2_skip_c1", 32'(skipped), 0);
        step();
        step();
        check_vec("movne2_we", 32'(rf_we), 1);
        check_vec("movne2_wdata", rf_wdata, 5);
        step();

        // Illegal encoding 0xE4000000
        send(32'hE400_0000);
`ifdef DP_SEQ_ILLEGAL_TRAP_EN
        check_vec("ill_skip_c1", 32'(skipped), 0);
        step();
        check_vec("ill_flag_c2", 32'(illegal), 1);
        check_vec("ill_ready_c2", 32'(instr_ready), 0);
        step();
        check_vec("ill_ready_c3", 32'(instr_ready), 0);
        check_vec("ill_we_c3", 32'(rf_we), 0);
        check_vec("ill_done_c3", 32'(done), 0);
`else
        check_vec("ill_skip_c1", 32'(skipped), 1);
        check_vec("ill_flag_c1", 32'(illegal), 0);
        step();
        check_vec("ill_ready_c2", 32'(instr_ready), 1);
        check_vec("ill_we_c2", 32'(rf_we), 0);
`endif

        // Reset during EXEC of ADDS
        if (!instr_ready) begin
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            step();
        end
        alu_f = 32'd0; alu_nzcv = 4'b0110;
        send(32'hE292_1001);
        step();
        check_vec("abort_wnzcv_exec", 32'(write_nzcv), 1);
        rst_n = 1'b0;
        #1;
        check_vec("abort_we", 32'(rf_we), 0);
        check_vec("abort_done", 32'(done), 0);
        check_vec("abort_aluop", 32'(alu_op), 0);
        step();
        step();
        check_vec("abort_we_late", 32'(rf_we), 0);
        check_vec("abort_nzcv", 32'(nzcv), 0);
        rst_n = 1'b1;
        step();
        check_vec("abort_ready", 32'(instr_ready), 1);
        check_vec("abort_illegal", 32'(illegal), 0);
        check_vec("abort_nzcv_after", 32'(nzcv), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dp_instr_sequencer.md
# dp_instr_sequencer

Multi-cycle controller for ARM data-processing instructions: the issuing end of the ALU/barrel-shifter datapath interface. It accepts one 32-bit instruction via valid/ready, evaluates its condition field against the committed NZCV register, reads operands, drives the ALU and shifter controls, and writes back the result and flags. It sits between instruction fetch and the ALU-shift datapath and owns the architectural NZCV register.

## Interface
- No parameters; all widths are fixed by the ISA.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid / instr_ready  in / out  1  instruction handshake; transfer when both are high on a clk edge
- instr  in  32  ARM data-processing encoding
- rf_raddr_a / rf_raddr_b / rf_raddr_c  out  4  read addresses for Rn, Rm and Rs; the register file read is combinational
- rf_rdata_a / rf_rdata_b / rf_rdata_c  in  32  read data
- alu_a  out 32, shift_data  out 32, shift_num  out 8, shift_op  out 3, alu_op  out 4, write_nzcv  out 1: datapath controls
- alu_f  in 32, alu_nzcv  in 4: datapath results
- rf_we  out 1, rf_waddr  out 4, rf_wdata  out 32: writeback port
- nzcv  out 4  committed flags {N,Z,C,V}; also feed the shifter carry-in
- done  out 1  one-cycle pulse when an instruction retires
- skipped  out 1  one-cycle pulse when an instruction is annulled
- illegal  out 1  see Configuration

## Operation
- FSM states: IDLE, DECODE, EXEC, WB.
  - IDLE: instr_ready=1. A handshake latches instr into IR and moves to DECODE.
  - DECODE: drive the read addresses from IR: a=IR[19:16], b=IR[3:0], c=IR[11:8]. Latch rdata into rn_q, rm_q, rs_q. Evaluate cond=IR[31:28] against nzcv.
    - cond passes -> EXEC.
    - cond fails -> IDLE, with skipped pulsed in that cycle.
  - EXEC: drive the datapath from the latched operands, with write_nzcv=IR[20]. Capture alu_f and alu_nzcv. Go to WB.
  - WB: rf_we=1 unless the opcode is TST/TEQ/CMP/CMN (8–11); rf_waddr=IR[15:12]; rf_wdata=captured F. If S=1, nzcv<=captured NZCV. Pulse done. Go to IDLE.
- Condition codes: ARM 0–14 with standard semantics. Code 15 (NV) always fails.
- Operand2 encoding, shift_op={type[1:0], amount_from_reg}:
  - I=1: shift_data=zero-extended IR[7:0], shift_num={3'b0,IR[11:8],1'b0}, shift_op=3'b110 (ROR, immediate amount).
  - I=0, IR[4]=0: shift_data=rm_q, shift_num={3'b0,IR[11:7]}, shift_op={IR[6:5],1'b0}.
  - I=0, IR[4]=1: shift_data=rm_q, shift_num=rs_q[7:0], shift_op={IR[6:5],1'b1}.
- alu_op=IR[24:21]; alu_a=rn_q.
- Rd=15 is written like any other register. No PC side effects.
- Writeback and flag update are independent; both may occur in the same WB cycle.

## Timing
- Reset values: state IDLE, instr_ready=1, nzcv=4'b0000. All other outputs are 0.
- Reset asserted mid-instruction: abort immediately. No rf_we, no nzcv change, no done.
- Executed instruction: handshake at edge 0; DECODE, EXEC and WB in cycles 1–3; done and rf_we in cycle 3; nzcv updated at edge 4; instr_ready high again in cycle 4.
- Annulled instruction: skipped in cycle 1; ready in cycle 2.
- Throughput: one instruction per 4 cycles.
- The datapath controls hold their EXEC values only during EXEC. Outside EXEC they are 0.
- A condition evaluated in DECODE sees the nzcv written by the previous instruction's WB, so there is no hazard.

## Configuration
- DP_SEQ_ILLEGAL_TRAP_EN covers illegal encodings: IR[27:26]≠00, or opcode 8–11 with S=0.
  - Defined: illegal goes high and is sticky until reset; the FSM parks in IDLE with instr_ready=0; no writes occur.
  - Undefined: illegal is tied to 0, and such instructions are treated exactly like a failed condition (skipped pulse, no writes).

## Structure
- Package dp_seq_pkg holds:
  - the state enum;
  - ALU opcode constants (AND=0 … MVN=15);
  - shift type constants (LSL=00, LSR=01, ASR=10, ROR=11);
  - condition code constants.
- Sub-module cond_check is combinational: (cond[3:0], nzcv[3:0]) -> pass.

## Test plan
- ADDS R1,R2,#1 (0xE2921001) with R2=0xFFFFFFFF -> rf_we in cycle 3 writing R1=0; nzcv=0110 after edge 4.
- MOVNE R0,#5 (0x13A00005) with nzcv Z=1 -> skipped in cycle 1; no rf_we; next handshake accepted in cycle 2.
- CMP R3,R4 (0xE1530004) with R3=R4=7 -> no rf_we; nzcv=0110; done in cycle 3.
- MOV R5,R6,LSL R7 (0xE1A05716) with R6=1, R7=4 -> EXEC drives shift_num=4, shift_op=001; R5=0x10.
- Illegal 0xE4000000 -> with the macro: illegal=1 and instr_ready stays 0. Without the macro: skipped pulse and normal flow.
- Assert rst_n in EXEC of ADDS -> no write; nzcv=0000; instr_ready=1 after release.
